// File: rtl/protocore_pkg.sv
// Shared definitions for the protocore control unit:
// opcodes, FSM states, instruction field positions.
package protocore_pkg;

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } cu_state_t;

   localparam logic [3:0] OP_LI   = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_BC   = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_ADDI = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RA_MSB  = 7;
   localparam int RA_LSB  = 4;
   localparam int RB_MSB  = 3;
   localparam int RB_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic go_mem;
      logic is_st;
      logic halt_op;
      logic flag_upd;
      logic pc_load;
   } ctl_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of IR into datapath controls
// and the flow hints consumed by the control FSM.
module cu_decoder
   import protocore_pkg::*;
(
   input  logic [15:0] ir,
   input  logic        exec,
   input  logic        mem,
   input  logic        mem_done,
   input  logic        z,
   input  logic        c,
   output ctl_t        ctl,
   output logic        write_alu,
   output logic [2:0]  alu_opcode,
   output logic [7:0]  imm_data,
   output logic [3:0]  write_addr,
   output logic [3:0]  ra_addr,
   output logic [3:0]  rb_addr,
   output logic        write_en,
   output logic        is_load,
   output logic        alu_imm_flag
);

   logic [3:0] op;
   logic [3:0] rd;
   logic rtype, addi, li, ld, st;
   logic bz, bc, jmp, hlt, we_raw;

   always_comb begin
      op    = ir[OP_MSB:OP_LSB];
      rd    = ir[RD_MSB:RD_LSB];
      rtype = 1'b0;
      addi  = 1'b0;
      li    = 1'b0;
      ld    = 1'b0;
      st    = 1'b0;
      bz    = 1'b0;
      bc    = 1'b0;
      jmp   = 1'b0;
      hlt   = 1'b0;
      unique case (1'b1)
         (op[3] == 1'b0):  rtype = 1'b1;
         (op == OP_LI):    li    = 1'b1;
         (op == OP_LD):    ld    = 1'b1;
         (op == OP_ST):    st    = 1'b1;
         (op == OP_BZ):    bz    = 1'b1;
         (op == OP_BC):    bc    = 1'b1;
         (op == OP_JMP):   jmp   = 1'b1;
         (op == OP_ADDI):  addi  = 1'b1;
         (op == OP_HALT):  hlt   = 1'b1;
      endcase
   end

   always_comb begin
      ctl.go_mem   = ld | st;
      ctl.is_st    = st;
      ctl.halt_op  = hlt;
      ctl.flag_upd = rtype | addi;
      ctl.pc_load  = jmp | (bz & z) | (bc & c);
   end

   always_comb begin
      write_alu    = 1'b0;
      alu_opcode   = 3'b000;
      imm_data     = 8'h00;
      write_addr   = 4'h0;
      ra_addr      = 4'h0;
      rb_addr      = 4'h0;
      is_load      = 1'b0;
      alu_imm_flag = 1'b0;
      we_raw       = 1'b0;
      if (exec || mem) begin
         write_addr = rd;
         ra_addr    = ir[RA_MSB:RA_LSB];
         rb_addr    = ir[RB_MSB:RB_LSB];
      end
      if (exec && rtype) begin
         write_alu  = 1'b1;
         alu_opcode = op[2:0];
         we_raw     = 1'b1;
      end
      if (exec && addi) begin
         write_alu    = 1'b1;
         alu_imm_flag = 1'b1;
         imm_data     = {4'h0, ir[RB_MSB:RB_LSB]};
         we_raw       = 1'b1;
      end
      if (exec && li) begin
         imm_data = ir[IMM_MSB:IMM_LSB];
         we_raw   = 1'b1;
      end
      if (mem && ld && mem_done) begin
         is_load = 1'b1;
         we_raw  = 1'b1;
      end
      // r0 is never written, whatever the instruction
      write_en = we_raw && (rd != 4'h0);
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, execute, memory wait, halt.
// Optional dmem wait timeout enabled by CU_MEM_TIMEOUT_EN.
module control_unit
   import protocore_pkg::*;
#(
   parameter logic [7:0] RESET_PC       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        write_alu,
   output logic [2:0]  alu_opcode,
   output logic [7:0]  imm_data,
   output logic [3:0]  write_addr,
   output logic [3:0]  ra_addr,
   output logic [3:0]  rb_addr,
   output logic        write_en,
   output logic        is_load,
   output logic        alu_imm_flag,
   input  logic        alu_zero,
   input  logic        alu_carry,
   output logic [7:0]  pc,
   output logic        halted,
   output logic        mem_err
);

   cu_state_t   state, state_nx;
   logic [15:0] ir;
   logic [7:0]  pc_q;
   logic        z_q, c_q, halted_q;
   logic        timeout;
   ctl_t        ctl;

   cu_decoder u_dec (
      .ir           (ir),
      .exec         (rst_n && state == S_EXEC),
      .mem          (rst_n && state == S_MEM),
      .mem_done     (dmem_ready),
      .z            (z_q),
      .c            (c_q),
      .ctl          (ctl),
      .write_alu    (write_alu),
      .alu_opcode   (alu_opcode),
      .imm_data     (imm_data),
      .write_addr   (write_addr),
      .ra_addr      (ra_addr),
      .rb_addr      (rb_addr),
      .write_en     (write_en),
      .is_load      (is_load),
      .alu_imm_flag (alu_imm_flag)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH: if (imem_valid) state_nx = S_EXEC;
         S_EXEC: begin
            if (ctl.go_mem)       state_nx = S_MEM;
            else if (ctl.halt_op) state_nx = S_HALT;
            else                  state_nx = S_FETCH;
         end
         S_MEM: begin
            if (dmem_ready)   state_nx = S_FETCH;
            else if (timeout) state_nx = S_HALT;
         end
         default: state_nx = S_HALT;
      endcase
   end

   // reqs are qualified by rst_n so they drop as soon as reset asserts
   always_comb begin
      imem_req  = rst_n && (state == S_FETCH);
      imem_addr = pc_q;
      dmem_req  = rst_n && (state == S_MEM);
      dmem_we   = dmem_req && ctl.is_st;
      pc        = pc_q;
      halted    = halted_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         ir       <= 16'h0000;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         if (state == S_FETCH && imem_valid) begin
            ir   <= imem_rdata;
            pc_q <= pc_q + 8'h01;
         end
         if (state == S_EXEC) begin
            if (ctl.flag_upd) begin
               z_q <= alu_zero;
               c_q <= alu_carry;
            end
            if (ctl.pc_load) pc_q <= ir[IMM_MSB:IMM_LSB];
            if (ctl.halt_op) halted_q <= 1'b1;
         end
         if (timeout) halted_q <= 1'b1;
      end
   end

`ifdef CU_MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          mem_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         if (state == S_MEM) to_cnt <= to_cnt + 1'b1;
         else                to_cnt <= '0;
         if (timeout) mem_err_q <= 1'b1;
      end
   end

   assign timeout = (state == S_MEM) && !dmem_ready &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign mem_err = mem_err_q;
`else
   assign timeout = 1'b0;
   assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed program,
// register-write events checked by a separate monitor.
module tb_control_unit;

   logic        clk, rst_n;
   logic        imem_req, imem_valid;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic        write_alu, write_en, is_load, alu_imm_flag;
   logic [2:0]  alu_opcode;
   logic [7:0]  imm_data, pc;
   logic [3:0]  write_addr, ra_addr, rb_addr;
   logic        alu_zero, alu_carry, halted, mem_err;

   int checks = 0;
   int failures = 0;

   logic [15:0] imem [256];
   int dly = 0;
   int mcnt = 0;
   int rlen = 0;
   int last_len = 0;
   logic rwe = 1'b0;
   logic last_we = 1'b0;

   logic [17:0] sbq [$];

   control_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ready(dmem_ready),
      .write_alu(write_alu), .alu_opcode(alu_opcode),
      .imm_data(imm_data), .write_addr(write_addr),
      .ra_addr(ra_addr), .rb_addr(rb_addr),
      .write_en(write_en), .is_load(is_load),
      .alu_imm_flag(alu_imm_flag),
      .alu_zero(alu_zero), .alu_carry(alu_carry),
      .pc(pc), .halted(halted), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_valid = imem_req;
   assign imem_rdata = imem[imem_addr];
   assign dmem_ready = dmem_req && (mcnt >= dly);

   always @(posedge clk)
      mcnt <= (dmem_req && !dmem_ready) ? mcnt + 1 : 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // {write_addr, imm_data, write_alu, is_load, alu_opcode, alu_imm_flag}
   function automatic logic [17:0] ev(input logic [3:0] wa,
                                      input logic [7:0] im,
                                      input logic wl, input logic ld,
                                      input logic [2:0] op,
                                      input logic imf);
      return {wa, im, wl, ld, op, imf};
   endfunction

   always @(negedge clk) begin
      if (dmem_req) begin
         rlen++;
         rwe = dmem_we;
      end else if (rlen != 0) begin
         last_len = rlen;
         last_we  = rwe;
         rlen     = 0;
      end
      if (is_load) chk("is_load_with_we", {31'd0, write_en}, 32'd1);
      if (write_en) begin
         if (sbq.size() == 0) begin
            chk("unexpected_write",
                {14'd0, ev(write_addr, imm_data, write_alu,
                           is_load, alu_opcode, alu_imm_flag)},
                32'd0);
         end else begin
            chk("write_event",
                {14'd0, ev(write_addr, imm_data, write_alu,
                           is_load, alu_opcode, alu_imm_flag)},
                {14'd0, sbq.pop_front()});
         end
      end
   end

   task automatic fetch_at(input logic [7:0] exp_pc);
      bit found = 0;
      for (int i = 0; i < 60; i++) begin
         if (imem_req) begin
            found = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!found) chk("fetch_timeout", 32'd0, {24'd0, exp_pc});
      else        chk("fetch_pc", {24'd0, pc}, {24'd0, exp_pc});
      @(negedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq;
      for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
      imem[8'h00] = 16'h8A5C;
      imem[8'h01] = 16'h0123;
      imem[8'h02] = 16'hB040;
      imem[8'h40] = 16'h1456;
      imem[8'h41] = 16'hB080;
      imem[8'h42] = 16'hC050;
      imem[8'h50] = 16'hE7A3;
      imem[8'h51] = 16'h9820;
      imem[8'h52] = 16'hA034;
      imem[8'h53] = 16'h8011;
      imem[8'h54] = 16'hD0FF;
      imem[8'hFF] = 16'h83AA;
      rst_n = 1'b0;
      alu_zero = 1'b0;
      alu_carry = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pc", {24'd0, pc}, 32'h00);
      chk("rst_status", {30'd0, halted, mem_err}, 32'd0);
      chk("rst_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
      rst_n = 1'b1;
      #1;

      sbq.push_back(ev(4'hA, 8'h5C, 1'b0, 1'b0, 3'd0, 1'b0));
      fetch_at(8'h00);
      imem[8'h00] = 16'hF000;
      alu_zero = 1'b1;
      alu_carry = 1'b0;
      sbq.push_back(ev(4'h1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0));
      fetch_at(8'h01);
      fetch_at(8'h02);
      alu_zero = 1'b0;
      alu_carry = 1'b1;
      sbq.push_back(ev(4'h4, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0));
      fetch_at(8'h40);
      fetch_at(8'h41);
      fetch_at(8'h42);
      alu_zero = 1'b0;
      alu_carry = 1'b0;
      sbq.push_back(ev(4'h7, 8'h03, 1'b1, 1'b0, 3'd0, 1'b1));
      fetch_at(8'h50);
      dly = 3;
      sbq.push_back(ev(4'h8, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0));
      fetch_at(8'h51);
      fetch_at(8'h52);
      chk("ld_req_cycles", last_len, 32'd4);
      chk("ld_we", {31'd0, last_we}, 32'd0);
      dly = 0;
      fetch_at(8'h53);
      chk("st_req_cycles", last_len, 32'd1);
      chk("st_we", {31'd0, last_we}, 32'd1);
      fetch_at(8'h54);
      sbq.push_back(ev(4'h3, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0));
      fetch_at(8'hFF);
      fetch_at(8'h00);

      nreq = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req || dmem_req) nreq++;
      end
      chk("halt_no_req", nreq, 32'd0);
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_pc", {24'd0, pc}, 32'h01);
      chk("mem_err_clear", {31'd0, mem_err}, 32'd0);

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst2_pc", {24'd0, pc}, 32'h00);
      chk("rst2_halted", {31'd0, halted}, 32'd0);
      imem[8'h00] = 16'h9120;
      dly = 1000;
      rst_n = 1'b1;
      #1;
      fetch_at(8'h00);
      for (int i = 0; i < 10 && !dmem_req; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("mid_mem_req", {31'd0, dmem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_drop_now", {30'd0, imem_req, dmem_req}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_drop_edge", {30'd0, imem_req, dmem_req}, 32'd0);
      chk("rst_mem_pc", {24'd0, pc}, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

`ifdef CU_MEM_TIMEOUT_EN
      imem[8'h00] = 16'hA012;
      fetch_at(8'h00);
      for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
      @(negedge clk);
      chk("to_req_cycles", last_len, 32'd16);
      chk("to_mem_err", {31'd0, mem_err}, 32'd1);
      chk("to_halted", {31'd0, halted}, 32'd1);
`else
      imem[8'h00] = 16'hF000;
      fetch_at(8'h00);
      repeat (3) @(negedge clk);
      chk("halt2", {31'd0, halted}, 32'd1);
      chk("mem_err_tied", {31'd0, mem_err}, 32'd0);
`endif

      chk("sb_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, dmem wait limit used only when CU_MEM_TIMEOUT_EN is defined.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows.
REQ-004 Port: clk, in, 1, sole clock, rising edge.
REQ-005 Port: rst_n, in, 1, synchronous active-low reset.
REQ-006 Ports: imem_req out 1, imem_addr out 8, imem_rdata in 16, imem_valid in 1; instruction fetch handshake.
REQ-007 Ports: dmem_req out 1, dmem_we out 1, dmem_ready in 1; data RAM handshake (address = datapath read_a, wdata = read_b, load data wired straight to the datapath).
REQ-008 Ports to datapath: write_alu 1, alu_opcode 3, imm_data 8, write_addr 4, ra_addr 4, rb_addr 4, write_en 1, is_load 1, alu_imm_flag 1 (all out).
REQ-009 Ports from datapath: alu_zero in 1, alu_carry in 1.
REQ-010 Status: pc out 8, halted out 1, mem_err out 1.

Function
REQ-011 Instruction fields: op=IR[15:12], rd=IR[11:8], ra=IR[7:4], rb=IR[3:0], imm8=IR[7:0].
REQ-012 Opcodes: 0x0-0x7 ALU R-type (alu_opcode=op[2:0]); 0x8 LI; 0x9 LD; 0xA ST; 0xB BZ; 0xC BC; 0xD JMP; 0xE ADDI4; 0xF HALT.
REQ-013 FSM states: FETCH, EXEC, MEM, HALT; the reset state is FETCH.
REQ-014 FETCH: imem_req=1 and imem_addr=pc; on imem_valid, IR<=imem_rdata, pc<=pc+1 (8'hFF wraps to 8'h00), next state EXEC.
REQ-015 EXEC: write_addr=rd, ra_addr=ra and rb_addr=rb are driven combinationally from IR.
REQ-016 R-type: write_alu=1 and write_en=1 for one cycle; Z<=alu_zero and C<=alu_carry in the same cycle; next state FETCH.
REQ-017 ADDI4: alu_opcode=000, alu_imm_flag=1, imm_data={4'h0,IR[3:0]}, write_alu=1, write_en=1; flags update; next state FETCH.
REQ-018 LI: imm_data=imm8, write_alu=0, is_load=0, write_en=1; flags are unchanged.
REQ-019 LD and ST: next state MEM; in MEM, dmem_req=1 and dmem_we=(op==ST).
REQ-020 LD: is_load=1, and write_en=1 only in the cycle dmem_ready=1.
REQ-021 MEM exits to FETCH on dmem_ready=1.
REQ-022 BZ/BC: if Z (respectively C) is 1, pc<=imm8, else pc is unchanged; JMP: pc<=imm8 unconditionally; one EXEC cycle.
REQ-023 HALT: enter state HALT and set halted=1; the FSM stays in HALT until reset, and no req is asserted.
REQ-024 write_en SHALL be forced to 0 whenever rd==0, in every case.
REQ-025 Outside the cases above, all datapath controls, imem_req and dmem_req SHALL be 0.
REQ-026 Latency: 2 cycles minimum per non-memory instruction, 3 minimum per LD/ST; wait states add cycles.

Reset
REQ-027 With rst_n=0 at the clock edge: state<=FETCH, pc<=RESET_PC, IR<=16'h0000, Z=C=0, halted=0, mem_err=0.
REQ-028 Reset applied during MEM or FETCH SHALL drop dmem_req/imem_req in the first cycle after that edge; no register write occurs.

Configuration
REQ-029 With CU_MEM_TIMEOUT_EN defined, a counter runs in MEM.
REQ-030 If dmem_ready is still 0 after TIMEOUT_CYCLES cycles in MEM, the block SHALL set mem_err=1, enter HALT and perform no write.
REQ-031 With CU_MEM_TIMEOUT_EN undefined, MEM waits indefinitely and mem_err is tied to 0.

Structure
REQ-032 Shared package protocore_pkg SHALL hold the opcode constants, the FSM state typedef and the instruction field positions.
REQ-033 Instruction decode SHALL live in one combinational sub-module, cu_decoder (IR -> datapath controls); the FSM, pc, IR and flags stay in control_unit.

Verification
REQ-034 Reset, then imem returns 16'h8A5C at pc 0 -> write_addr=A, imm_data=5C, write_en=1 for 1 cycle, pc=01.
REQ-035 R-type add with alu_zero=1 returned, then BZ 8'h40 -> pc=40 on the next FETCH; repeat with alu_zero=0 -> pc increments.
REQ-036 LD with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, write_en and is_load high only in the ready cycle.
REQ-037 pc=FF, then a non-branch instruction fetched -> pc=00; instruction with rd=0 -> write_en stays 0.
REQ-038 HALT fetched -> halted=1, no req for 20 cycles; rst_n low mid-MEM -> reqs drop within 1 cycle, pc=RESET_PC.
REQ-039 With CU_MEM_TIMEOUT_EN defined, ST with dmem_ready held 0 -> mem_err=1 and halted=1 after 16 cycles.
